run_detect_sched: RTL and testbench

- Schedules a shared serial run-length detector between two word-level requesters.
- Round-robin arbiter accepts one WIDTH-bit word at a time over valid/ready.
- Shifts the word LSB-first, one bit per cycle, through an internal detector that flags runs of RUN equal bits (the "four 0s / four 1s" detector generalised).
- Returns the requester id and hit count over a valid/ready result channel.

---
 rtl/run_detect_sched.sv | 138 +++++++++++++
 tb/tb_run_detect_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_detect_sched.sv
// rtl/run_detect_sched.sv - round-robin shared serial run-length detector
// Two word requesters share one LSB-first detector; each word yields one id/hit-count result.
module run_detect_sched #(
   parameter int WIDTH = 8,
   parameter int RUN   = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             res_valid,
   output logic             res_id,
   output logic [CNT_W-1:0] res_hits,
   input  logic             res_ready,
   output logic             det_out,
   output logic             busy
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = $clog2(RUN + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [RW-1:0] RUN_V    = RW'(RUN);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [RW-1:0]    run_q, run_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] hits_q, hits_d;
   logic             det_q, det_d;

   logic             grant0, grant1;
   logic             bit_v;
   logic [RW-1:0]    run_new;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      sreg_d       = sreg_q;
      bitcnt_d     = bitcnt_q;
      run_d        = run_q;
      prev_d       = prev_q;
      hits_d       = hits_q;
      det_d        = det_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      bit_v        = sreg_q[0];
      run_new      = run_q;

      case (state_q)
         IDLE: begin
            // On contention the requester that did not win last time is favoured.
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
            if (grant0 || grant1) begin
               sreg_d       = grant1 ? req1_data : req0_data;
               id_d         = grant1;
               last_grant_d = grant1;
               bitcnt_d     = '0;
               run_d        = '0;
               hits_d       = '0;
               det_d        = 1'b0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = sreg_q >> 1;
            if (bitcnt_q == '0 || bit_v != prev_q) begin
               run_new = RW'(1);
            end else if (run_q == RUN_V) begin
               run_new = RUN_V;
            end else begin
               run_new = run_q + RW'(1);
            end
            run_d  = run_new;
            prev_d = bit_v;
            det_d  = (run_new == RUN_V);
            // Run length pins at RUN so every further equal bit scores another hit.
            if (run_new == RUN_V && hits_q != '1) begin
               hits_d = hits_q + CNT_W'(1);
            end
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         sreg_q       <= '0;
         bitcnt_q     <= '0;
         run_q        <= '0;
         prev_q       <= 1'b0;
         hits_q       <= '0;
         det_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         sreg_q       <= sreg_d;
         bitcnt_q     <= bitcnt_d;
         run_q        <= run_d;
         prev_q       <= prev_d;
         hits_q       <= hits_d;
         det_q        <= det_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_valid  = (state_q == DONE);
   assign res_id     = id_q;
   assign res_hits   = hits_q;
   assign det_out    = det_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_run_detect_sched.sv
// tb/tb_run_detect_sched.sv - self-checking bench for run_detect_sched
// Directed and random words checked against a look-back run-length model.
module tb_run_detect_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_ready, req1_ready, res_valid, res_id, det_out, busy;
   logic [3:0] res_hits;

   logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_res_ready = 1'b0;
   logic [7:0] b_req0_data = '0, b_req1_data = '0;
   logic       b_req0_ready, b_req1_ready, b_res_valid, b_res_id, b_det_out, b_busy;
   logic [1:0] b_res_hits;

   int errors = 0;
   int checks = 0;
   logic last_id = 1'b1;

   always #5 clk = ~clk;

   run_detect_sched #(.WIDTH(8), .RUN(4), .CNT_W(4)) dut (
      .clk(clk), .reset(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits), .res_ready(res_ready),
      .det_out(det_out), .busy(busy)
   );

   run_detect_sched #(.WIDTH(8), .RUN(2), .CNT_W(2)) dut2 (
      .clk(clk), .reset(rst_n),
      .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
      .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
      .res_valid(b_res_valid), .res_id(b_res_id), .res_hits(b_res_hits), .res_ready(b_res_ready),
      .det_out(b_det_out), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Length of the equal-bit run ending at bit i, looking back within the word only.
   function automatic int run_len(input logic [7:0] d, input int i);
      int n = 1;
      for (int j = i - 1; j >= 0; j--) begin
         if (d[j] != d[i]) break;
         n++;
      end
      return n;
   endfunction

   function automatic int model_hits(input logic [7:0] d, input int run, input int cntw);
      int h = 0;
      int mx = (1 << cntw) - 1;
      for (int i = 0; i < 8; i++) if (run_len(d, i) >= run) h++;
      return (h > mx) ? mx : h;
   endfunction

   task automatic do_word(input logic id, input logic [7:0] d, input logic both,
                          input int exp_hits, input int hold);
      if (id) req1_data = d; else req0_data = d;
      if (both) begin
         if (id) req0_data = 8'($urandom); else req1_data = 8'($urandom);
         req0_valid = 1'b1;
         req1_valid = 1'b1;
      end else begin
         req0_valid = !id;
         req1_valid = id;
      end
      #1;
      chk("ready_granted", id ? req1_ready : req0_ready, 1);
      chk("ready_other", id ? req0_ready : req1_ready, 0);
      chk("busy_idle", busy, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("busy_shift", busy, 1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("det_bit", det_out, (run_len(d, i) >= 4) ? 1 : 0);
         if (i < 7) chk("res_valid_early", res_valid, 0);
      end
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, id);
      chk("res_hits", res_hits, exp_hits);
      if (hold > 0) begin
         req0_data = 8'hF0;
         req0_valid = 1'b1;
         repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, id);
            chk("hold_hits", res_hits, exp_hits);
            chk("hold_readys", {req0_ready, req1_ready}, 0);
            chk("hold_busy", busy, 1);
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
      chk("busy_after", busy, 0);
      if (hold > 0) chk("pending_ready", req0_ready, 1);
      last_id = id;
   endtask

   initial begin
      int   grants, prev_c, seen;
      logic last_g;
      logic [7:0] dd [2];
      logic [7:0] d;
      logic id, both;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {req0_ready, req1_ready, res_valid, res_id, res_hits, det_out, busy}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_word(1'b0, 8'h00, 1'b0, 5, 0);
      do_word(1'b1, 8'h55, 1'b0, 0, 0);

      // Continuous contention: alternating grants, one accept per 10 cycles.
      dd[0] = 8'($urandom);
      dd[1] = 8'($urandom);
      req0_data = dd[0];
      req1_data = dd[1];
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready = 1'b1;
      grants = 0;
      prev_c = 0;
      last_g = 1'b0;
      for (int c = 0; c < 80 && grants < 4; c++) begin
         #1;
         if (res_valid) begin
            chk("rr_res_id", res_id, last_g);
            chk("rr_res_hits", res_hits, model_hits(dd[last_g], 4, 4));
         end
         if (req0_ready || req1_ready) begin
            chk("rr_one_ready", req0_ready & req1_ready, 0);
            chk("rr_order", req1_ready, grants % 2);
            if (grants > 0) chk("rr_spacing", c - prev_c, 10);
            prev_c = c;
            last_g = req1_ready;
            grants++;
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("rr_grants", grants, 4);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (res_valid) begin
            chk("rr_last_hits", res_hits, model_hits(dd[last_g], 4, 4));
            seen = 1;
         end else if (seen != 0) begin
            break;
         end
         @(posedge clk); #1;
      end
      chk("rr_drain", seen, 1);
      chk("rr_idle", busy, 0);
      res_ready = 1'b0;
      last_id = 1'b1;

      do_word(1'b0, 8'h0F, 1'b0, 2, 0);
      d = 8'($urandom);
      do_word(1'b1, d, 1'b0, model_hits(d, 4, 4), 5);
      do_word(1'b0, 8'hF0, 1'b0, model_hits(8'hF0, 4, 4), 0);

      for (int n = 0; n < 16; n++) begin
         d = 8'($urandom);
         both = 1'($urandom);
         id = both ? !last_id : 1'($urandom);
         do_word(id, d, both, model_hits(d, 4, 4), 0);
      end

      // Reset in mid-word discards it and restores the req0-first preference.
      req0_data = 8'($urandom);
      req0_valid = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {req0_ready, req1_ready, res_valid, res_id, res_hits, det_out, busy}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (res_valid || busy) seen = 1;
      end
      chk("rst_no_result", seen, 0);
      last_id = 1'b1;
      d = 8'($urandom);
      do_word(1'b0, d, 1'b1, model_hits(d, 4, 4), 0);

      // Short-run instance saturates its 2-bit counter.
      b_req0_data = 8'h00;
      b_req0_valid = 1'b1;
      #1;
      chk("b_ready", b_req0_ready, 1);
      @(posedge clk); #1;
      b_req0_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (b_res_valid) begin
            seen = 1;
            break;
         end
      end
      chk("b_res_valid", seen, 1);
      chk("b_res_hits_sat", b_res_hits, model_hits(8'h00, 2, 2));
      b_res_ready = 1'b1;
      @(posedge clk); #1;
      b_res_ready = 1'b0;
      chk("b_idle", b_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
